rx_symbol_packer: RTL and testbench

//  RX stage directly downstream of the elastic buffer, in the local_clock domain.

---
 rtl/rx_pkg.sv | 30 +++
 rtl/rx_symbol_packer_if.sv | 25 ++
 rtl/rx_error_monitor.sv | 60 ++++++
 rtl/rx_symbol_packer.sv | 171 +++++++++++++++++
 tb/tb_rx_symbol_packer.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared RX constants and types. The elastic buffer uses the same symbol
// encodings, so keep these in one place.
package rx_pkg;

  localparam int SYMBOL_W = 10;
  localparam int WORD_W   = 32;
  localparam int LANES    = 4;

  // Symbol encoding: [9]=decode error, [8]=K flag, [7:0]=byte
  localparam logic [SYMBOL_W-1:0] COMMA_SYMBOL = 10'h1BC;
  localparam logic [SYMBOL_W-1:0] SKIP_SYMBOL  = 10'h1A1;

  // Default tuning of the lock / error policy
  localparam int DEF_LOCK_COUNT = 3;
  localparam int DEF_ERR_LIMIT  = 4;
  localparam int DEF_ERR_WINDOW = 64;

  typedef struct packed {
    logic       err;
    logic       k;
    logic [7:0] data;
  } rx_symbol_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } rx_lock_state_t;

endpackage

// File: rtl/rx_symbol_packer_if.sv
// Symbol input / packed word output bundle of the RX symbol packer.
// slave = packer side, master = producer/consumer side.
interface rx_symbol_packer_if;
  import rx_pkg::*;

  logic [SYMBOL_W-1:0] data_in;
  logic                data_in_valid;
  logic [WORD_W-1:0]   word_out;
  logic [LANES-1:0]    word_k;
  logic                word_valid;
  logic                locked;
  logic                align_error;
  logic [15:0]         err_count;

  modport slave (
    input  data_in, data_in_valid,
    output word_out, word_k, word_valid, locked, align_error, err_count
  );

  modport master (
    output data_in, data_in_valid,
    input  word_out, word_k, word_valid, locked, align_error, err_count
  );

endinterface

// File: rtl/rx_error_monitor.sv
// Decode error bookkeeping: sliding-free error window over accepted
// symbols while locked, plus a saturating lifetime error counter.
module rx_error_monitor
  import rx_pkg::*;
#(
  parameter int ERR_LIMIT  = DEF_ERR_LIMIT,
  parameter int ERR_WINDOW = DEF_ERR_WINDOW
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        i_locked,     // FSM is in LOCKED
  input  logic        i_sym_acc,    // valid, non-SKP symbol this cycle
  input  logic        i_sym_err,    // that symbol carries a decode error
  input  logic        i_count_err,  // error that counts toward err_count
  output logic        o_lose_lock,  // window error limit reached this cycle
  output logic [15:0] o_err_count
);

  localparam int WIN_W  = $clog2(ERR_WINDOW);
  localparam int ERRC_W = $clog2(ERR_LIMIT + 1);

  logic [WIN_W-1:0]  r_win_cnt;
  logic [ERRC_W-1:0] r_win_err;
  logic [15:0]       r_err_count;

  logic              w_win_tick;
  logic              w_wrap;
  logic [ERRC_W-1:0] w_win_err_inc;

  assign w_win_tick    = i_locked & i_sym_acc;
  assign w_wrap        = w_win_tick && (r_win_cnt == WIN_W'(ERR_WINDOW - 1));
  assign w_win_err_inc = r_win_err + ERRC_W'(1);
  // The limit check uses the old window count, so an error on the wrap
  // cycle is judged against the window it closes.
  assign o_lose_lock   = w_win_tick && i_sym_err && (w_win_err_inc >= ERRC_W'(ERR_LIMIT));
  assign o_err_count   = r_err_count;

  // Window position and per-window error count; idle (cleared) when not locked.
  always_ff @(posedge clk) begin
    if (srst || !i_locked) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (w_win_tick) begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
      if (w_wrap)
        r_win_err <= '0;
      else if (i_sym_err)
        r_win_err <= w_win_err_inc;
    end
  end

  // Lifetime decode error counter, saturating.
  always_ff @(posedge clk) begin
    if (srst)
      r_err_count <= '0;
    else if (i_count_err && (r_err_count != 16'hFFFF))
      r_err_count <= r_err_count + 16'd1;
  end

endmodule

// File: rtl/rx_symbol_packer.sv
// RX symbol packer: drops SKP filler, acquires comma lock and packs
// decoded bytes (with K flags) into 32-bit words, first byte in lane 0.
module rx_symbol_packer
  import rx_pkg::*;
#(
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int ERR_LIMIT  = DEF_ERR_LIMIT,
  parameter int ERR_WINDOW = DEF_ERR_WINDOW
) (
  input  logic         local_clock,
  input  logic         reset,
  rx_symbol_packer_if.slave rx
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  rx_lock_state_t    r_state, w_state_next;
  logic [CNT_W-1:0]  r_comma_cnt, w_comma_cnt_next;
  logic [1:0]        r_lane, w_lane_next;
  logic              w_wr_en;
  logic              w_word_done;
  logic              w_align_err;

  logic [WORD_W-1:0] r_word_out;
  logic [LANES-1:0]  r_word_k;
  logic              r_word_valid;
  logic              r_align_error;

  rx_symbol_t        w_sym;
  logic              w_acc;
  logic              w_is_comma;
  logic              w_lose_lock;
  logic              w_count_err;
  logic [7:0]        w_lane_byte;
  logic              w_lane_k;
  logic [WORD_W-1:0] w_word_cat;
  logic [LANES-1:0]  w_k_cat;
  logic [15:0]       w_err_count;

  assign w_sym       = rx.data_in;
  assign w_acc       = rx.data_in_valid && (rx.data_in != SKIP_SYMBOL);
  assign w_is_comma  = (rx.data_in == COMMA_SYMBOL);
  assign w_count_err = w_acc && w_sym.err && ((r_state == LOCKING) || (r_state == LOCKED));
  // Errored symbols still occupy a lane, as a plain zero byte.
  assign w_lane_byte = w_sym.err ? 8'h00 : w_sym.data;
  assign w_lane_k    = w_sym.err ? 1'b0 : w_sym.k;

  rx_error_monitor #(
    .ERR_LIMIT  (ERR_LIMIT),
    .ERR_WINDOW (ERR_WINDOW)
  ) u_err_mon (
    .clk         (local_clock),
    .srst        (reset),
    .i_locked    (r_state == LOCKED),
    .i_sym_acc   (w_acc),
    .i_sym_err   (w_sym.err),
    .i_count_err (w_count_err),
    .o_lose_lock (w_lose_lock),
    .o_err_count (w_err_count)
  );

  // Lock FSM state, comma counter and lane pointer.
  always_ff @(posedge local_clock) begin
    if (reset) begin
      r_state     <= UNLOCKED;
      r_comma_cnt <= '0;
      r_lane      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_comma_cnt <= w_comma_cnt_next;
      r_lane      <= w_lane_next;
    end
  end

  // Next-state logic and per-symbol pack decisions.
  always_comb begin
    w_state_next     = r_state;
    w_comma_cnt_next = r_comma_cnt;
    w_lane_next      = r_lane;
    w_wr_en          = 1'b0;
    w_word_done      = 1'b0;
    w_align_err      = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        UNLOCKED: begin
          if (w_is_comma) begin
            w_state_next     = LOCKING;
            w_comma_cnt_next = CNT_W'(1);
          end
        end
        LOCKING: begin
          if (w_is_comma) begin
            if (r_comma_cnt == CNT_W'(LOCK_COUNT - 1)) begin
              w_state_next     = LOCKED;
              w_comma_cnt_next = '0;
              w_lane_next      = '0;
            end else begin
              w_comma_cnt_next = r_comma_cnt + CNT_W'(1);
            end
          end else if (w_sym.err) begin
            w_state_next     = UNLOCKED;
            w_comma_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (w_is_comma) begin
            // Comma realigns to lane 0; anything partially packed is abandoned.
            w_lane_next = '0;
            w_align_err = (r_lane != 2'd0);
          end else if (w_lose_lock) begin
            w_state_next = UNLOCKED;
            w_lane_next  = '0;
          end else begin
            w_wr_en     = 1'b1;
            w_lane_next = r_lane + 2'd1;
            w_word_done = (r_lane == 2'd3);
          end
        end
        default: w_state_next = UNLOCKED;
      endcase
    end
  end

  // Lanes 0..2 are stored; lane 3 completes the word straight from the input.
  for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
    logic [7:0] r_byte;
    logic       r_k;

    // Capture this lane's byte when the pointer is on it.
    always_ff @(posedge local_clock) begin
      if (reset) begin
        r_byte <= '0;
        r_k    <= 1'b0;
      end else if (w_wr_en && (r_lane == 2'(gi))) begin
        r_byte <= w_lane_byte;
        r_k    <= w_lane_k;
      end
    end

    assign w_word_cat[8*gi +: 8] = r_byte;
    assign w_k_cat[gi]           = r_k;
  end

  assign w_word_cat[WORD_W-1 -: 8] = w_lane_byte;
  assign w_k_cat[LANES-1]          = w_lane_k;

  // Word output register (held until next word) and one-cycle strobes.
  always_ff @(posedge local_clock) begin
    if (reset) begin
      r_word_out    <= '0;
      r_word_k      <= '0;
      r_word_valid  <= 1'b0;
      r_align_error <= 1'b0;
    end else begin
      r_word_valid  <= w_word_done;
      r_align_error <= w_align_err;
      if (w_word_done) begin
        r_word_out <= w_word_cat;
        r_word_k   <= w_k_cat;
      end
    end
  end

  assign rx.word_out    = r_word_out;
  assign rx.word_k      = r_word_k;
  assign rx.word_valid  = r_word_valid;
  assign rx.align_error = r_align_error;
  assign rx.locked      = (r_state == LOCKED);
  assign rx.err_count   = w_err_count;

endmodule

// File: tb/tb_rx_symbol_packer.sv
// Self-checking bench for rx_symbol_packer: expected words are queued as
// stimulus is driven and compared by a monitor whenever word_valid pulses.
module tb_rx_symbol_packer;
  import rx_pkg::*;

  logic local_clock = 1'b0;
  logic reset;

  rx_symbol_packer_if bus ();

  rx_symbol_packer dut (
    .local_clock (local_clock),
    .reset       (reset),
    .rx          (bus.slave)
  );

  always #5 local_clock = ~local_clock;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  k;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Scoreboard monitor: every word_valid pulse must match the oldest queued word.
  always @(negedge local_clock) begin
    if (bus.word_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_word: got word_out=%h word_k=%b, required no word_valid",
                 bus.word_out, bus.word_k);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.word_out !== mon_e.word || bus.word_k !== mon_e.k) begin
          n_errors++;
          $display("FAIL word: got %h k=%b, required %h k=%b",
                   bus.word_out, bus.word_k, mon_e.word, mon_e.k);
        end else begin
          $display("word %h k=%b ok", bus.word_out, bus.word_k);
        end
      end
    end
  end

  task automatic send(input logic [9:0] s);
    bus.data_in       = s;
    bus.data_in_valid = 1'b1;
    @(negedge local_clock);
    bus.data_in_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic [9:0] s);
    bus.data_in       = s;
    bus.data_in_valid = 1'b0;
    @(negedge local_clock);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [3:0] k);
    exp_t e;
    e.word = w;
    e.k    = k;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    repeat (3) @(negedge local_clock);
    reset = 1'b0;
    @(negedge local_clock);
    n_checks++;
    if (bus.locked !== 1'b0 || bus.word_valid !== 1'b0 || bus.align_error !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got locked=%b word_valid=%b align_error=%b, required 0 0 0",
               bus.locked, bus.word_valid, bus.align_error);
    end
    n_checks++;
    if (bus.word_out !== 32'h0 || bus.word_k !== 4'h0 || bus.err_count !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_data: got word_out=%h word_k=%b err_count=%0d, required 0",
               bus.word_out, bus.word_k, bus.err_count);
    end
    // Data and errors while UNLOCKED are ignored and not counted.
    send(10'h011);
    send(10'h2AA);
    n_checks++;
    if (bus.err_count !== 16'd0 || bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL unlocked_ignore: got err_count=%0d locked=%b, required 0 0",
               bus.err_count, bus.locked);
    end
    $display("test_reset done");
  endtask

  task automatic test_lock_and_pack();
    logic exp_lock;
    for (int i = 0; i < 3; i++) begin
      send(COMMA_SYMBOL);
      exp_lock = (i == 2);
      n_checks++;
      if (bus.locked !== exp_lock) begin
        n_errors++;
        $display("FAIL lock_acquire comma %0d: got locked=%b, required %b", i + 1, bus.locked, exp_lock);
      end
    end
    push_word(32'h44332211, 4'b0000);
    send(10'h011);
    send(10'h022);
    send(10'h033);
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL early_word_valid: got %b, required 0", bus.word_valid);
    end
    send(10'h044);
    n_checks++;
    if (bus.word_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL word_latency: got word_valid=%b, required 1", bus.word_valid);
    end
    idle_cycle(10'h000);
    n_checks++;
    if (bus.word_valid !== 1'b0 || bus.word_out !== 32'h44332211) begin
      n_errors++;
      $display("FAIL word_pulse_hold: got word_valid=%b word_out=%h, required 0 44332211",
               bus.word_valid, bus.word_out);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL lock_pack_drain: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_lock_and_pack done");
  endtask

  task automatic test_skip();
    send(COMMA_SYMBOL);
    n_checks++;
    if (bus.align_error !== 1'b0) begin
      n_errors++;
      $display("FAIL aligned_comma: got align_error=%b, required 0", bus.align_error);
    end
    push_word(32'hDDCCBBAA, 4'b0000);
    send(SKIP_SYMBOL);
    send(10'h0AA);
    send(SKIP_SYMBOL);
    send(10'h0BB);
    idle_cycle(COMMA_SYMBOL);   // not valid: must not realign
    send(10'h0CC);
    send(10'h0DD);
    idle_cycle(10'h000);
    n_checks++;
    if (exp_q.size() != 0 || bus.align_error !== 1'b0) begin
      n_errors++;
      $display("FAIL skip_drain: got %0d pending align_error=%b, required 0 0",
               exp_q.size(), bus.align_error);
      exp_q.delete();
    end
    $display("test_skip done");
  endtask

  task automatic test_align();
    push_word(32'h66554433, 4'b0000);
    send(10'h011);
    send(10'h022);
    send(COMMA_SYMBOL);
    n_checks++;
    if (bus.align_error !== 1'b1) begin
      n_errors++;
      $display("FAIL align_pulse: got align_error=%b, required 1", bus.align_error);
    end
    send(10'h033);
    n_checks++;
    if (bus.align_error !== 1'b0) begin
      n_errors++;
      $display("FAIL align_pulse_width: got align_error=%b, required 0", bus.align_error);
    end
    send(10'h044);
    send(10'h055);
    send(10'h066);
    idle_cycle(10'h000);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL align_drain: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_align done");
  endtask

  task automatic test_k_flags();
    push_word(32'hFE03F701, 4'b1010);
    send(10'h001);
    send(10'h1F7);
    send(10'h003);
    send(10'h1FE);
    idle_cycle(10'h000);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL k_drain: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_k_flags done");
  endtask

  task automatic test_error_lock_loss();
    logic [9:0] errs [4];
    errs[0] = 10'h2FF;
    errs[1] = 10'h3BC;
    errs[2] = 10'h255;
    errs[3] = 10'h2AA;
    for (int i = 0; i < 3; i++) begin
      send(errs[i]);
      n_checks++;
      if (bus.locked !== 1'b1) begin
        n_errors++;
        $display("FAIL err_below_limit %0d: got locked=%b, required 1", i + 1, bus.locked);
      end
    end
    send(errs[3]);   // lands on lane 3 but must not complete a word
    n_checks++;
    if (bus.locked !== 1'b0 || bus.word_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL err_limit: got locked=%b word_valid=%b, required 0 0", bus.locked, bus.word_valid);
    end
    n_checks++;
    if (bus.err_count !== 16'd4 || bus.word_out !== 32'hFE03F701) begin
      n_errors++;
      $display("FAIL err_count_hold: got err_count=%0d word_out=%h, required 4 fe03f701",
               bus.err_count, bus.word_out);
    end
    idle_cycle(10'h000);
    $display("test_error_lock_loss done");
  endtask

  task automatic test_window();
    logic [31:0] acc_w;
    logic [3:0]  acc_k;
    int          lane;
    logic        is_err;
    logic [9:0]  sym;
    for (int i = 0; i < 3; i++) send(COMMA_SYMBOL);
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_errors++;
      $display("FAIL window_relock: got locked=%b, required 1", bus.locked);
    end
    acc_w = '0;
    acc_k = '0;
    lane  = 0;
    // 3 errors, 64 clean symbols, 3 errors: the window wrap in between
    // must clear the window error count.
    for (int i = 0; i < 70; i++) begin
      is_err = (i < 3) || (i >= 67);
      sym    = is_err ? (10'h200 | 10'(i)) : 10'(i);
      acc_w[8*lane +: 8] = is_err ? 8'h00 : sym[7:0];
      acc_k[lane]        = 1'b0;
      if (lane == 3) push_word(acc_w, acc_k);
      lane = (lane + 1) % 4;
      send(sym);
      if (i >= 67) begin
        n_checks++;
        if (bus.locked !== 1'b1) begin
          n_errors++;
          $display("FAIL window_clear at symbol %0d: got locked=%b, required 1", i, bus.locked);
        end
      end
    end
    idle_cycle(10'h000);
    n_checks++;
    if (bus.err_count !== 16'd10 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL window_totals: got err_count=%0d pending=%0d, required 10 0",
               bus.err_count, exp_q.size());
      exp_q.delete();
    end
    $display("test_window done");
  endtask

  task automatic test_locking_abort();
    reset = 1'b1;
    repeat (2) @(negedge local_clock);
    reset = 1'b0;
    n_checks++;
    if (bus.err_count !== 16'd0 || bus.locked !== 1'b0 || bus.word_out !== 32'h0) begin
      n_errors++;
      $display("FAIL rereset: got err_count=%0d locked=%b word_out=%h, required 0 0 0",
               bus.err_count, bus.locked, bus.word_out);
    end
    send(COMMA_SYMBOL);
    send(COMMA_SYMBOL);
    send(10'h2AA);
    n_checks++;
    if (bus.locked !== 1'b0 || bus.err_count !== 16'd1) begin
      n_errors++;
      $display("FAIL locking_err: got locked=%b err_count=%0d, required 0 1", bus.locked, bus.err_count);
    end
    send(COMMA_SYMBOL);
    send(COMMA_SYMBOL);
    send(SKIP_SYMBOL);
    n_checks++;
    if (bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL relock_early: got locked=%b after 2 commas, required 0", bus.locked);
    end
    send(COMMA_SYMBOL);
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_errors++;
      $display("FAIL relock: got locked=%b after 3 commas, required 1", bus.locked);
    end
    send(10'h011);
    send(10'h022);
    reset = 1'b1;
    @(negedge local_clock);
    reset = 1'b0;
    n_checks++;
    if (bus.locked !== 1'b0 || bus.word_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_midword: got locked=%b word_valid=%b, required 0 0", bus.locked, bus.word_valid);
    end
    for (int i = 0; i < 3; i++) send(COMMA_SYMBOL);
    push_word(32'h08070605, 4'b0000);
    send(10'h005);
    send(10'h006);
    send(10'h007);
    send(10'h008);
    idle_cycle(10'h000);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL abort_drain: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_locking_abort done");
  endtask

  initial begin
    test_reset();
    test_lock_and_pack();
    test_skip();
    test_align();
    test_k_flags();
    test_error_lock_loss();
    test_window();
    test_locking_abort();
    repeat (2) @(negedge local_clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
